fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter DEPTH, default 8, capacity of the attached FIFO in words.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 flush  in  1  single-cycle request to empty the FIFO.
REQ-006 push_req  in  1  producer requests a write; held until push_ack.
REQ-007 push_data  in  DATA_W  write word; stable while push_req high.
REQ-008 push_ack  out  1  one-cycle pulse: word written this cycle.
REQ-009 pop_req  in  1  consumer requests a read; held until pop_ack.
REQ-010 pop_ack  out  1  one-cycle pulse: FIFO read this cycle.
REQ-011 pop_data  out  DATA_W  registered read word.
REQ-012 pop_valid  out  1  one-cycle pulse: pop_data holds the popped word.
REQ-013 fifo_rst  out  1  to FIFO rst.
REQ-014 fifo_ce  out  1  to FIFO ce.
REQ-015 fifo_we  out  1  to FIFO we.
REQ-016 fifo_wdata  out  DATA_W  to FIFO data_i.
REQ-017 fifo_rdata  in  DATA_W  from FIFO data_o (combinational, valid when fifo_ce=1, fifo_we=0).
REQ-018 count  out  $clog2(DEPTH)+1  words held, 0..DEPTH.
REQ-019 empty / full  out  1 each  count==0 / count==DEPTH.

Function
REQ-020 FSM states IDLE, PUSH, POP; each granted operation occupies exactly one PUSH or POP cycle.
REQ-021 IDLE: push eligible = push_req & count<DEPTH; pop eligible = pop_req & count>0; exactly one eligible -> go to its state; neither -> stay IDLE.
REQ-022 Both eligible: round-robin on last_grant; grant side opposite to last_grant; last_grant updates on every grant.
REQ-023 PUSH (one cycle): fifo_ce=1, fifo_we=1, fifo_wdata=push_data, push_ack=1, count+1, next state IDLE.
REQ-024 POP (one cycle): fifo_ce=1, fifo_we=0, pop_ack=1, pop_data<=fifo_rdata, count-1, next state IDLE; pop_valid=1 in the following cycle only.
REQ-025 Outside PUSH/POP: fifo_ce=0, fifo_we=0, push_ack=0, pop_ack=0; fifo_wdata=push_data.
REQ-026 Latency req-to-ack: 1 cycle minimum when uncontended; pop data visible 2 cycles after pop_req sampled in IDLE; max throughput one op per 2 cycles.
REQ-027 count never exceeds DEPTH nor goes below 0; push at full and pop at empty stall (no ack) until eligible.
REQ-028 flush: fifo_rst=1 for that cycle; count<=0, state<=IDLE, no ack issued that cycle, in-progress PUSH/POP cancelled (its ack suppressed, count unchanged by it).
REQ-029 fifo_rst = rst | flush, combinational.
REQ-030 Requester dropping req before ack is a protocol violation; behaviour unspecified except count stays within bounds.

Reset
REQ-031 On rst: state IDLE, count 0, last_grant=POP (first contention grants PUSH), pop_data 0, pop_valid 0, all acks 0, fifo_ce 0, fifo_we 0, fifo_rst 1.
REQ-032 rst during PUSH/POP cancels the operation identically to flush.

Structure
REQ-033 Shared package nn_fifo_pkg holds DATA_W, DEPTH, COUNT_W and the FSM state enum; fifo_buffer uses the same constants.
REQ-034 No sub-module; arbitration and FSM live in fifo_arbiter, instantiated beside fifo_buffer in the wishbone_nn top.

Verification
REQ-035 Reset, then push_req with push_data 0xA5A5_0001..0xA5A5_0008 -> 8 push_acks, count=8, full=1; ninth push_req gets no ack.
REQ-036 From full, pop_req held -> pop_data 0xA5A5_0001..0008 in order with pop_valid, count=0, empty=1; further pop_req gets no ack.
REQ-037 count=4, push_req and pop_req both held -> acks alternate PUSH, POP, PUSH, ... starting with PUSH after reset; count oscillates 4/5.
REQ-038 count=3, flush asserted during a PUSH cycle -> no push_ack that cycle, fifo_rst=1, count=0, next push lands at FIFO slot 0.
REQ-039 Push 10 and pop 10 words interleaved (wrap past DEPTH) -> popped sequence equals pushed sequence, count returns to 0.

Source files
------------

// File: rtl/nn_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_fifo_pkg
// Brief    : Shared FIFO sizing constants and FSM/grant encodings.
// Revision : 1.0 - initial release
// ============================================================================
package nn_fifo_pkg;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_PUSH = 1'b0,
        GRANT_POP  = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arbiter
// Brief    : Round-robin push/pop arbiter driving a single-port FIFO buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_arbiter
    import nn_fifo_pkg::*;
#(
    parameter int DATA_W = nn_fifo_pkg::DATA_W,
    parameter int DEPTH  = nn_fifo_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_req,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     push_ack,
    input  logic                     pop_req,
    output logic                     pop_ack,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     pop_valid,
    output logic                     fifo_rst,
    output logic                     fifo_ce,
    output logic                     fifo_we,
    output logic [DATA_W-1:0]        fifo_wdata,
    input  logic [DATA_W-1:0]        fifo_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int                 c_COUNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_COUNT_W-1:0] c_FULL  = c_COUNT_W'(DEPTH);

    state_t                r_state;
    grant_t                r_last_grant;
    logic [c_COUNT_W-1:0]  r_count;
    logic [DATA_W-1:0]     r_pop_data;
    logic                  r_pop_valid;

    logic                  w_cancel;
    logic                  w_push_elig;
    logic                  w_pop_elig;

    // A flush or reset landing on a PUSH/POP cycle kills that operation outright.
    assign w_cancel    = rst | flush;
    assign w_push_elig = push_req & (r_count < c_FULL);
    assign w_pop_elig  = pop_req & (r_count != '0);

    assign fifo_rst   = w_cancel;
    assign fifo_ce    = ((r_state == ST_PUSH) | (r_state == ST_POP)) & ~w_cancel;
    assign fifo_we    = (r_state == ST_PUSH) & ~w_cancel;
    assign fifo_wdata = push_data;
    assign push_ack   = (r_state == ST_PUSH) & ~w_cancel;
    assign pop_ack    = (r_state == ST_POP) & ~w_cancel;

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_POP;
            r_count      <= '0;
            r_pop_data   <= '0;
            r_pop_valid  <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_push_elig && w_pop_elig) begin
                            if (r_last_grant == GRANT_POP) begin
                                r_state      <= ST_PUSH;
                                r_last_grant <= GRANT_PUSH;
                            end else begin
                                r_state      <= ST_POP;
                                r_last_grant <= GRANT_POP;
                            end
                        end else if (w_push_elig) begin
                            r_state      <= ST_PUSH;
                            r_last_grant <= GRANT_PUSH;
                        end else if (w_pop_elig) begin
                            r_state      <= ST_POP;
                            r_last_grant <= GRANT_POP;
                        end
                    end
                    ST_PUSH: begin
                        r_count <= r_count + 1'b1;
                        r_state <= ST_IDLE;
                    end
                    ST_POP: begin
                        r_count     <= r_count - 1'b1;
                        r_pop_data  <= fifo_rdata;
                        r_pop_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_arbiter
// Brief    : Directed self-checking bench for fifo_arbiter with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_arbiter;

    localparam int c_DW    = 32;
    localparam int c_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              push_req = 1'b0;
    logic [c_DW-1:0]   push_data = '0;
    logic              push_ack;
    logic              pop_req = 1'b0;
    logic              pop_ack;
    logic [c_DW-1:0]   pop_data;
    logic              pop_valid;
    logic              fifo_rst;
    logic              fifo_ce;
    logic              fifo_we;
    logic [c_DW-1:0]   fifo_wdata;
    logic [c_DW-1:0]   fifo_rdata;
    logic [3:0]        count;
    logic              empty;
    logic              full;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    fifo_arbiter #(.DATA_W(c_DW), .DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
        .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data), .pop_valid(pop_valid),
        .fifo_rst(fifo_rst), .fifo_ce(fifo_ce), .fifo_we(fifo_we),
        .fifo_wdata(fifo_wdata), .fifo_rdata(fifo_rdata),
        .count(count), .empty(empty), .full(full)
    );

    // Behavioural single-port FIFO buffer standing in for fifo_buffer.
    logic [c_DW-1:0] mem [c_DEPTH];
    logic [2:0]      wp = '0, rp = '0, last_waddr = '0;
    assign fifo_rdata = mem[rp];
    always @(posedge clk) begin
        if (fifo_rst) begin
            wp <= '0;
            rp <= '0;
        end else if (fifo_ce && fifo_we) begin
            mem[wp]    <= fifo_wdata;
            last_waddr <= wp;
            wp         <= wp + 3'd1;
        end else if (fifo_ce) begin
            rp <= rp + 3'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] data);
        bit got = 0;
        push_req  = 1'b1;
        push_data = data;
        for (int n = 0; n < 6 && !got; n++) begin
            tick();
            if (push_ack) got = 1;
        end
        check("push_ack", {31'd0, got}, 32'd1);
        push_req = 1'b0;
        tick();
        if (got) exp_count++;
        check("count_after_push", {28'd0, count}, exp_count);
    endtask

    task automatic pop_word(input logic [31:0] exp_data);
        bit got = 0;
        pop_req = 1'b1;
        for (int n = 0; n < 6 && !got; n++) begin
            tick();
            if (pop_ack) got = 1;
        end
        check("pop_ack", {31'd0, got}, 32'd1);
        pop_req = 1'b0;
        tick();
        if (got) exp_count--;
        check("pop_valid", {31'd0, pop_valid}, 32'd1);
        check("pop_data", pop_data, exp_data);
        check("count_after_pop", {28'd0, count}, exp_count);
        tick();
        check("pop_valid_pulse", {31'd0, pop_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_fifo_rst", {31'd0, fifo_rst}, 32'd1);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ce", {31'd0, fifo_ce}, 32'd0);
        check("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
        check("rst_pop_data", pop_data, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_fifo_rst", {31'd0, fifo_rst}, 32'd0);

        // Fill to full, then a ninth push must stall
        for (int i = 1; i <= 8; i++) push_word(32'hA5A5_0000 + i);
        check("full_flag", {31'd0, full}, 32'd1);
        push_req  = 1'b1;
        push_data = 32'hA5A5_0009;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("push_at_full_ack", {31'd0, push_ack}, 32'd0);
        end
        push_req = 1'b0;
        tick();
        check("count_full", {28'd0, count}, 32'd8);

        // Drain in order, then a further pop must stall
        for (int i = 1; i <= 8; i++) pop_word(32'hA5A5_0000 + i);
        check("empty_flag", {31'd0, empty}, 32'd1);
        pop_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("pop_at_empty_ack", {31'd0, pop_ack}, 32'd0);
        end
        pop_req = 1'b0;
        tick();

        // count=4 with last grant POP, then hold both requests
        for (int i = 1; i <= 5; i++) push_word(32'hB000_0000 + i);
        pop_word(32'hB000_0001);
        push_req  = 1'b1;
        pop_req   = 1'b1;
        push_data = 32'hC000_0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("arb_push_ack", {31'd0, push_ack}, (k % 4 == 1) ? 32'd1 : 32'd0);
            check("arb_pop_ack", {31'd0, pop_ack}, (k % 4 == 3) ? 32'd1 : 32'd0);
            check("arb_count", {28'd0, count}, (k % 4 == 2 || k % 4 == 3) ? 32'd5 : 32'd4);
            if (k == 4) check("arb_pop_data0", pop_data, 32'hB000_0002);
            if (k == 8) check("arb_pop_data1", pop_data, 32'hB000_0003);
            if (push_ack) push_data = push_data + 32'd1;
        end
        push_req = 1'b0;
        pop_req  = 1'b0;
        tick();

        // count=3, flush lands on a PUSH cycle
        pop_word(32'hB000_0004);
        check("count_three", {28'd0, count}, 32'd3);
        push_req  = 1'b1;
        push_data = 32'hD000_0001;
        tick();
        flush = 1'b1;
        #1;
        check("flush_push_ack", {31'd0, push_ack}, 32'd0);
        check("flush_fifo_rst", {31'd0, fifo_rst}, 32'd1);
        check("flush_ce", {31'd0, fifo_ce}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_count", {28'd0, count}, 32'd0);
        exp_count = 0;
        push_req = 1'b0;
        push_word(32'hD000_0001);
        check("flush_slot0", {29'd0, last_waddr}, 32'd0);

        // Interleaved push/pop wrapping past DEPTH
        pop_word(32'hD000_0001);
        for (int i = 0; i < 10; i++) begin
            push_word(32'hE000_0000 + i);
            pop_word(32'hE000_0000 + i);
        end
        check("final_count", {28'd0, count}, 32'd0);
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
